flame_sequencer: RTL

FLAME_SEQUENCER -- requirements
Module: flame_sequencer

---
 rtl/flame_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/flame_sequencer.sv
// Bomb fuse and flame animation sequencer.
// Tracks fuse frames, then plays a 9-step flame sprite sequence.
module flame_sequencer #(
  parameter int unsigned FUSE_FRAMES = 120,
  parameter int unsigned ANIM_DIV    = 6,
  parameter logic [9:0]  PARK_POS    = 10'd1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       drop,
  input  logic [9:0] drop_x,
  input  logic [9:0] drop_y,
  output logic       bomb_active,
  output logic       flame_active,
  output logic [9:0] flame_centerX,
  output logic [9:0] flame_centerY,
  output logic [2:0] sprite_num,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    EXPLODE
  } state_t;

  localparam logic [7:0] FUSE_INIT = 8'(FUSE_FRAMES);
  localparam logic [3:0] HOLD_LAST = 4'(ANIM_DIV - 1);
  localparam logic [9:0] MAX_X     = 10'd768;
  localparam logic [9:0] MAX_Y     = 10'd568;

  state_t     state_q, state_d;
  logic [7:0] fuse_q, fuse_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] step_q, step_d;
  logic [9:0] pos_x_q, pos_x_d;
  logic [9:0] pos_y_q, pos_y_d;
  logic       fin;

  logic [9:0] tile_x, tile_y;
  logic [9:0] snap_x, snap_y;

  logic       bomb_d, flame_d;
  logic [9:0] cx_d, cy_d;
  logic [2:0] spr_d;

  assign tile_x = {drop_x[9:5], 5'd0};
  assign tile_y = {drop_y[9:5], 5'd0};
  assign snap_x = (tile_x > MAX_X) ? MAX_X : tile_x;
  assign snap_y = (tile_y > MAX_Y) ? MAX_Y : tile_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fuse_q  <= '0;
      hold_q  <= '0;
      step_q  <= '0;
      pos_x_q <= '0;
      pos_y_q <= '0;
    end else begin
      state_q <= state_d;
      fuse_q  <= fuse_d;
      hold_q  <= hold_d;
      step_q  <= step_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
    end
  end

  // done is still high in the first IDLE cycle, which masks a drop there
  always_comb begin
    state_d = state_q;
    fuse_d  = fuse_q;
    hold_d  = hold_q;
    step_d  = step_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    fin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (drop && !done) begin
          pos_x_d = snap_x;
          pos_y_d = snap_y;
          fuse_d  = FUSE_INIT;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (frame_tick) begin
          fuse_d = fuse_q - 8'd1;
          if (fuse_q == 8'd1) begin
            state_d = EXPLODE;
            step_d  = '0;
            hold_d  = '0;
          end
        end
      end
      EXPLODE: begin
        if (frame_tick) begin
          if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            if (step_q == 4'd8) begin
              state_d = IDLE;
              step_d  = '0;
              fin     = 1'b1;
            end else begin
              step_d = step_q + 4'd1;
            end
          end else begin
            hold_d = hold_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next state so the registers line up with state_q
  always_comb begin
    bomb_d  = (state_d == ARMED);
    flame_d = (state_d == EXPLODE);
    cx_d    = PARK_POS;
    cy_d    = PARK_POS;
    spr_d   = '0;
    if (state_d == EXPLODE) begin
      cx_d  = pos_x_d;
      cy_d  = pos_y_d;
      spr_d = (step_d <= 4'd4) ? step_d[2:0] : 3'(4'd8 - step_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bomb_active   <= 1'b0;
      flame_active  <= 1'b0;
      flame_centerX <= PARK_POS;
      flame_centerY <= PARK_POS;
      sprite_num    <= '0;
      done          <= 1'b0;
    end else begin
      bomb_active   <= bomb_d;
      flame_active  <= flame_d;
      flame_centerX <= cx_d;
      flame_centerY <= cy_d;
      sprite_num    <= spr_d;
      done          <= fin;
    end
  end

endmodule
